// File: rtl/instr_cycle_ctrl.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives the datapath load enables and
// memory strobes, and guards the memory handshake with a timeout.
module instr_cycle_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             HALT_REQ,
  input  logic             MEM_RDY,
  input  logic             IS_MEM,
  input  logic             IS_STORE,
  input  logic             IS_WB,
  output logic [2:0]       STATE,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic             IR_LOAD,
  output logic             PC_LOAD,
  output logic             RF_WRITE,
  output logic             HALTED,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);

  // Wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_halt_pend;
  logic                r_is_mem;
  logic                r_is_store;
  logic                r_is_wb;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_ir_load;
  logic                w_rf_write;
  logic                w_retire;
  logic                w_timeout;
  state_t              w_retire_tgt;

  // Where a retiring instruction goes: halt if one is pending or requested now.
  assign w_retire_tgt = (r_halt_pend || HALT_REQ) ? S_HALT : S_FETCH;

  // Next-state, wait-counter and strobe decode; stalls wait on MEM_RDY, and ready beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = {WAIT_W{1'b0}};
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_load   = 1'b0;
    w_rf_write  = 1'b0;
    w_retire    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (MEM_RDY) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_wait_nxt  = r_wait + WAIT_W'(1);
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (r_is_mem) begin
          w_state_nxt = S_MEMORY;
        end else if (r_is_wb) begin
          w_state_nxt = S_WRITEBACK;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = w_retire_tgt;
        end
      end
      S_MEMORY: begin
        if (r_is_store) begin
          w_mem_write = 1'b1;
        end else begin
          w_mem_read = 1'b1;
        end
        if (MEM_RDY) begin
          if (r_is_wb) begin
            w_state_nxt = S_WRITEBACK;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = w_retire_tgt;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_wait_nxt  = r_wait + WAIT_W'(1);
          w_state_nxt = S_MEMORY;
        end
      end
      S_WRITEBACK: begin
        w_rf_write  = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = w_retire_tgt;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, wait counter, halt flag, class capture, error flag and retire counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_wait      <= {WAIT_W{1'b0}};
      r_halt_pend <= 1'b0;
      r_is_mem    <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_wb     <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (HALT_REQ && (r_state != S_HALT)) begin
        r_halt_pend <= 1'b1;
      end
      if (r_state == S_DECODE) begin
        r_is_mem   <= IS_MEM;
        r_is_store <= IS_MEM & IS_STORE;
        r_is_wb    <= IS_WB;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_retire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Strobes are held low for the whole time reset is asserted.
  assign MEM_READ  = w_mem_read  & ~RST;
  assign MEM_WRITE = w_mem_write & ~RST;
  assign IR_LOAD   = w_ir_load   & ~RST;
  assign PC_LOAD   = w_retire    & ~RST;
  assign RF_WRITE  = w_rf_write  & ~RST;
  assign STATE     = r_state;
  assign HALTED    = (r_state == S_HALT);
  assign ERR       = r_err;
  assign INSTR_CNT = r_cnt;

endmodule
